// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall sequencer: load-use bubbles, data-cache miss stalls with a
// refill watchdog, run-start pipeline flush and a saturating stall counter.
module pipe_stall_ctrl #(
  parameter int unsigned TMO_W    = 8,
  parameter int unsigned RSTP_CYC = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_run_i,
  input  logic        ld_use_hazard_ex_i,
  input  logic        dc_miss_ma_i,
  input  logic        dc_fill_done_i,
  output logic        stall_o,
  output logic        stall_dly_o,
  output logic        dc_stall_o,
  output logic        dc_stall_fin_o,
  output logic        rst_pipe_o,
  output logic        dc_timeout_o,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic [2:0] {StIdle, StLdUse, StDcWait, StDcFin, StRstp} state_e;

  localparam logic [3:0] RstpLoad = 4'(RSTP_CYC - 1);

  state_e             state_q, state_d;
  logic               run_q;
  logic [3:0]         rstp_cnt_q, rstp_cnt_d;
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic               timeout_q, timeout_d;
  logic               stall_dly_q, stall_dly_d;
  logic [31:0]        stall_cycles_q, stall_cycles_d;
  logic               stall, dc_stall, dc_stall_fin, rst_pipe;
  logic               run_rise;

  assign run_rise = cpu_run_i & ~run_q;

  always_comb begin
    state_d      = state_q;
    rstp_cnt_d   = rstp_cnt_q;
    wdog_d       = wdog_q;
    timeout_d    = timeout_q;
    stall        = 1'b0;
    dc_stall     = 1'b0;
    dc_stall_fin = 1'b0;
    rst_pipe     = 1'b0;

    unique case (state_q)
      // LDUSE shares the IDLE decode but ignores the load-use request.
      StIdle, StLdUse: begin
        if (dc_miss_ma_i) begin
          stall    = 1'b1;
          dc_stall = 1'b1;
          wdog_d   = '0;
          state_d  = StDcWait;
        end else if (ld_use_hazard_ex_i && (state_q == StIdle)) begin
          stall   = 1'b1;
          state_d = StLdUse;
        end else begin
          state_d = StIdle;
        end
      end
      StDcWait: begin
        stall    = 1'b1;
        dc_stall = 1'b1;
        wdog_d   = wdog_q + 1'b1;
        if (dc_fill_done_i) begin
          state_d = StDcFin;
        end else if (&wdog_q) begin
          timeout_d = 1'b1;
          state_d   = StDcFin;
        end
      end
      StDcFin: begin
        dc_stall     = 1'b1;
        dc_stall_fin = 1'b1;
        state_d      = StIdle;
      end
      StRstp: begin
        rst_pipe = 1'b1;
        if (rstp_cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          rstp_cnt_d = rstp_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A run start overrides whatever sequence is in flight.
    if (run_rise) begin
      state_d    = StRstp;
      rstp_cnt_d = RstpLoad;
      timeout_d  = 1'b0;
    end

    stall_dly_d = run_rise ? 1'b0 : stall;

    if (run_rise) begin
      stall_cycles_d = '0;
    end else if (stall && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      run_q          <= 1'b0;
      rstp_cnt_q     <= '0;
      wdog_q         <= '0;
      timeout_q      <= 1'b0;
      stall_dly_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      run_q          <= cpu_run_i;
      rstp_cnt_q     <= rstp_cnt_d;
      wdog_q         <= wdog_d;
      timeout_q      <= timeout_d;
      stall_dly_q    <= stall_dly_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_o        = stall;
  assign dc_stall_o     = dc_stall;
  assign dc_stall_fin_o = dc_stall_fin;
  assign rst_pipe_o     = rst_pipe;
  assign stall_dly_o    = stall_dly_q;
  assign dc_timeout_o   = timeout_q;
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed sequences plus random stimulus, all
// compared against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

  localparam int unsigned TmoW    = 4;
  localparam int unsigned RstpCyc = 2;
  localparam int          WdogMax = (1 << TmoW) - 1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cpu_run_i = 1'b0;
  logic        ld_use_hazard_ex_i = 1'b0;
  logic        dc_miss_ma_i = 1'b0;
  logic        dc_fill_done_i = 1'b0;
  logic        stall_o, stall_dly_o, dc_stall_o, dc_stall_fin_o, rst_pipe_o, dc_timeout_o;
  logic [31:0] stall_cycles_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_i = ~clk_i;

  pipe_stall_ctrl #(
    .TMO_W   (TmoW),
    .RSTP_CYC(RstpCyc)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .cpu_run_i         (cpu_run_i),
    .ld_use_hazard_ex_i(ld_use_hazard_ex_i),
    .dc_miss_ma_i      (dc_miss_ma_i),
    .dc_fill_done_i    (dc_fill_done_i),
    .stall_o           (stall_o),
    .stall_dly_o       (stall_dly_o),
    .dc_stall_o        (dc_stall_o),
    .dc_stall_fin_o    (dc_stall_fin_o),
    .rst_pipe_o        (rst_pipe_o),
    .dc_timeout_o      (dc_timeout_o),
    .stall_cycles_o    (stall_cycles_o)
  );

  // Behavioural model: phases tracked as plain counters and flags.
  bit          m_run_prev, m_waiting, m_fin, m_bubble_done, m_timeout, m_stall_prev;
  int          m_rstp_left, m_wait_age;
  logic [31:0] m_cnt;
  bit          e_stall, e_dc_stall, e_fin, e_rst_pipe;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run_prev = 0; m_waiting = 0; m_fin = 0; m_bubble_done = 0;
    m_timeout = 0; m_stall_prev = 0; m_rstp_left = 0; m_wait_age = 0; m_cnt = '0;
  endtask

  task automatic model_out();
    e_stall = 0; e_dc_stall = 0; e_fin = 0; e_rst_pipe = 0;
    if (m_rstp_left > 0) begin
      e_rst_pipe = 1;
    end else if (m_waiting) begin
      e_stall = 1; e_dc_stall = 1;
    end else if (m_fin) begin
      e_dc_stall = 1; e_fin = 1;
    end else if (dc_miss_ma_i) begin
      e_stall = 1; e_dc_stall = 1;
    end else if (ld_use_hazard_ex_i && !m_bubble_done) begin
      e_stall = 1;
    end
  endtask

  task automatic model_next();
    bit rise;
    rise = cpu_run_i && !m_run_prev;
    m_run_prev = cpu_run_i;
    if (rise) m_cnt = '0;
    else if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    m_stall_prev = rise ? 1'b0 : e_stall;
    if (rise) begin
      m_timeout = 0; m_rstp_left = RstpCyc; m_waiting = 0; m_fin = 0; m_bubble_done = 0;
    end else if (m_rstp_left > 0) begin
      m_rstp_left--;
    end else if (m_waiting) begin
      if (dc_fill_done_i) begin
        m_waiting = 0; m_fin = 1;
      end else if (m_wait_age == WdogMax) begin
        m_waiting = 0; m_fin = 1; m_timeout = 1;
      end else begin
        m_wait_age++;
      end
    end else if (m_fin) begin
      m_fin = 0;
    end else if (dc_miss_ma_i) begin
      m_waiting = 1; m_wait_age = 0; m_bubble_done = 0;
    end else if (ld_use_hazard_ex_i && !m_bubble_done) begin
      m_bubble_done = 1;
    end else begin
      m_bubble_done = 0;
    end
  endtask

  // Inputs are set just after a negedge; compare mid-low-phase, then advance.
  task automatic step();
    #1;
    model_out();
    check_eq("stall", 32'(stall_o), 32'(e_stall));
    check_eq("dc_stall", 32'(dc_stall_o), 32'(e_dc_stall));
    check_eq("dc_stall_fin", 32'(dc_stall_fin_o), 32'(e_fin));
    check_eq("rst_pipe", 32'(rst_pipe_o), 32'(e_rst_pipe));
    check_eq("stall_dly", 32'(stall_dly_o), 32'(m_stall_prev));
    check_eq("dc_timeout", 32'(dc_timeout_o), 32'(m_timeout));
    check_eq("stall_cycles", stall_cycles_o, m_cnt);
    model_next();
    @(negedge clk_i);
  endtask

  task automatic drive(input bit run, input bit ld, input bit miss, input bit fill);
    cpu_run_i = run; ld_use_hazard_ex_i = ld; dc_miss_ma_i = miss; dc_fill_done_i = fill;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, 32'(stall_o), 32'd0);
    check_eq({tag, "_dc_stall"}, 32'(dc_stall_o), 32'd0);
    check_eq({tag, "_fin"}, 32'(dc_stall_fin_o), 32'd0);
    check_eq({tag, "_rst_pipe"}, 32'(rst_pipe_o), 32'd0);
    check_eq({tag, "_stall_dly"}, 32'(stall_dly_o), 32'd0);
    check_eq({tag, "_timeout"}, 32'(dc_timeout_o), 32'd0);
    check_eq({tag, "_cycles"}, stall_cycles_o, 32'd0);
  endtask

  initial begin
    model_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 0, 0, 0); step(); step();

    // Load-use held two cycles: one bubble only.
    drive(0, 1, 0, 0); step();
    check_eq("lu_dly0", 32'(stall_dly_o), 32'd1);
    step();
    drive(0, 0, 0, 0); step();
    check_eq("lu_cycles", stall_cycles_o, 32'd1);

    // Miss with fill on the 4th wait cycle: 5 stall cycles, then DC_FIN.
    drive(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step();
    drive(0, 0, 1, 1); step();
    drive(0, 0, 0, 0);
    #1;
    check_eq("miss_fin", 32'(dc_stall_fin_o), 32'd1);
    check_eq("miss_cycles", stall_cycles_o, 32'd6);
    step(); step();

    // Miss beats load-use.
    drive(0, 1, 1, 0); step();
    drive(0, 1, 1, 1); step();
    drive(0, 0, 0, 0); step(); step();

    // Watchdog expiry with no fill.
    drive(0, 0, 1, 0);
    for (int i = 0; i < WdogMax + 2; i++) step();
    #1;
    check_eq("wd_fin", 32'(dc_stall_fin_o), 32'd1);
    check_eq("wd_timeout", 32'(dc_timeout_o), 32'd1);
    drive(0, 0, 0, 0); step();

    // Run start mid-miss clears timeout/counter and flushes for RstpCyc cycles.
    drive(0, 0, 1, 0); step(); step(); step();
    drive(1, 0, 1, 0); step();
    for (int i = 0; i < RstpCyc; i++) begin
      #1;
      check_eq("rstp_pulse", 32'(rst_pipe_o), 32'd1);
      check_eq("rstp_cycles", stall_cycles_o, 32'd0);
      step();
    end
    drive(1, 0, 0, 0); step();
    check_eq("rstp_done", 32'(rst_pipe_o), 32'd0);

    // Fill on the expiry cycle: fill wins, no timeout.
    drive(1, 0, 1, 0);
    for (int i = 0; i < WdogMax + 1; i++) step();
    drive(1, 0, 1, 1); step();
    drive(0, 0, 0, 0); step();
    check_eq("wd_fill_wins", 32'(dc_timeout_o), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0) ? ~cpu_run_i : cpu_run_i,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0));
      step();
    end

    // Saturation: preload near the top, then a long miss.
    drive(0, 0, 0, 0); step(); step();
    force dut.stall_cycles_q = 32'hFFFF_FFF8;
    #1;
    release dut.stall_cycles_q;
    m_cnt = 32'hFFFF_FFF8;
    drive(0, 0, 1, 0);
    for (int i = 0; i < WdogMax + 2; i++) step();
    drive(0, 0, 0, 0); step();
    check_eq("sat_hold", stall_cycles_o, 32'hFFFF_FFFF);

    // Async reset in the middle of DC_WAIT.
    drive(0, 0, 1, 0); step(); step(); step();
    #2;
    rst_ni = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 1, 0, 0); step();
    drive(0, 0, 0, 0); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
